// File: rtl/pq_pkg.sv
// Shared types and widths for the hardware priority queue.
// A cell carries a timestamp (data) and an entry id; the reader FSM
// state type lives here so the insert side and tooling can share it.
package pq_pkg;

  localparam int unsigned TIME_WIDTH = 8;
  localparam int unsigned ID_WIDTH   = 4;
  // The payload of a queue cell is its timestamp.
  localparam int unsigned DATA_WIDTH = TIME_WIDTH;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
  } cell_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_POP,
    RD_SETTLE
  } rd_state_e;

endpackage

// File: rtl/pq_time_base.sv
// Free-running time base: a prescaler divides clk by PRESCALE and the
// now counter advances by one on each prescaler wrap (modulo 2^TIME_WIDTH).
// Shared by the insert and expiry sides of the priority queue.
module pq_time_base #(
  parameter int unsigned TIME_WIDTH = 8,
  parameter int unsigned PRESCALE   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic [TIME_WIDTH-1:0] now_o
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]       presc_q;
  logic [TIME_WIDTH-1:0] now_q;
  logic                  tick;

  assign tick  = (presc_q == PS_W'(PRESCALE - 1));
  assign now_o = now_q;

  // Prescaler wraps at PRESCALE-1; each wrap advances the time base.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      now_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PS_W'(1);
      if (tick) now_q <= now_q + TIME_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pq_expiry_reader.sv
// Consumer end of the priority queue: watches the head timestamp against
// the local time base, pops expired entries and presents {id,time} on a
// valid/ready port.
// Optional feature: define PQ_LATE_CNT_EN to count pops whose head was
// already past due (saturating 16-bit counter); otherwise late_cnt_o is 0.
module pq_expiry_reader
  import pq_pkg::*;
#(
  parameter int unsigned TIME_WIDTH = pq_pkg::TIME_WIDTH,
  parameter int unsigned ID_WIDTH   = pq_pkg::ID_WIDTH,
  parameter int unsigned PRESCALE   = 1,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  cell_t                 head_i,
  input  logic                  head_valid_i,
  output logic                  pop_o,
  output logic [TIME_WIDTH-1:0] now_o,
  output logic                  exp_valid_o,
  output logic [ID_WIDTH-1:0]   exp_id_o,
  output logic [TIME_WIDTH-1:0] exp_time_o,
  input  logic                  exp_ready_i,
  output logic [15:0]           late_cnt_o
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);
  // Half of the time range: differences below this are in the past.
  localparam logic [TIME_WIDTH-1:0] HALF = {1'b1, {(TIME_WIDTH-1){1'b0}}};

  rd_state_e             state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  pop_q;
  logic                  exp_valid_q;
  logic [ID_WIDTH-1:0]   exp_id_q;
  logic [TIME_WIDTH-1:0] exp_time_q;

  logic [TIME_WIDTH-1:0] now;
  logic [TIME_WIDTH-1:0] head_time;
  logic [TIME_WIDTH-1:0] diff;
  logic                  expired;
  logic                  out_free;
  logic                  transfer;
  logic                  go;

  pq_time_base #(
    .TIME_WIDTH (TIME_WIDTH),
    .PRESCALE   (PRESCALE)
  ) u_time_base (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .now_o  (now)
  );

  assign head_time = TIME_WIDTH'(head_i.data);
  // Wrap-safe: a head is due when now is at most half the range past it.
  assign diff      = now - head_time;
  assign expired   = (diff < HALF);
  assign transfer  = exp_valid_q & exp_ready_i;
  assign out_free  = ~exp_valid_q | exp_ready_i;
  assign go        = (state_q == RD_IDLE) & en_i & head_valid_i & expired & out_free;

  // Reader FSM with registered pop strobe and output register. The settle
  // counter is loaded on entry to POP and counts SETTLE_CYC..1 across POP
  // and SETTLE, so the next head evaluation is SETTLE_CYC+1 cycles after
  // the previous one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RD_IDLE;
      cnt_q       <= '0;
      pop_q       <= 1'b0;
      exp_valid_q <= 1'b0;
      exp_id_q    <= '0;
      exp_time_q  <= '0;
    end else begin
      // NOTE: a later non-blocking assignment in the same block wins, so a
      // POP reload below overrides this clear for back-to-back transfers.
      if (transfer) exp_valid_q <= 1'b0;
      case (state_q)
        RD_IDLE: begin
          if (go) begin
            state_q <= RD_POP;
            pop_q   <= 1'b1;
            cnt_q   <= CNT_W'(SETTLE_CYC);
          end
        end
        RD_POP: begin
          pop_q       <= 1'b0;
          exp_valid_q <= 1'b1;
          exp_id_q    <= ID_WIDTH'(head_i.id);
          exp_time_q  <= head_time;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RD_IDLE;
          end else begin
            state_q <= RD_SETTLE;
            cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        RD_SETTLE: begin
          if (cnt_q == CNT_W'(1)) state_q <= RD_IDLE;
          else                    cnt_q   <= cnt_q - CNT_W'(1);
        end
        default: begin
          state_q <= RD_IDLE;
          pop_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pop_o       = pop_q;
  assign now_o       = now;
  assign exp_valid_o = exp_valid_q;
  assign exp_id_o    = exp_id_q;
  assign exp_time_o  = exp_time_q;

`ifdef PQ_LATE_CNT_EN
  logic [15:0] late_q;

  // Count pops whose head was strictly past due; saturates at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      late_q <= '0;
    end else if (go && (diff != '0) && (late_q != 16'hFFFF)) begin
      late_q <= late_q + 16'd1;
    end
  end

  assign late_cnt_o = late_q;
`else
  assign late_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_pq_expiry_reader.sv
// Self-checking bench for pq_expiry_reader: directed scenarios plus random
// traffic, compared every cycle against a behavioural model that works
// from elapsed cycles, modular time arithmetic and a cooldown count.
module tb_pq_expiry_reader;
  import pq_pkg::*;

  localparam int PRESCALE   = 2;
  localparam int SETTLE_CYC = 3;
  localparam int TMOD       = 1 << TIME_WIDTH;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  en_i;
  cell_t                 head_i;
  logic                  head_valid_i;
  logic                  pop_o;
  logic [TIME_WIDTH-1:0] now_o;
  logic                  exp_valid_o;
  logic [ID_WIDTH-1:0]   exp_id_o;
  logic [TIME_WIDTH-1:0] exp_time_o;
  logic                  exp_ready_i;
  logic [15:0]           late_cnt_o;

  pq_expiry_reader #(
    .TIME_WIDTH (TIME_WIDTH),
    .ID_WIDTH   (ID_WIDTH),
    .PRESCALE   (PRESCALE),
    .SETTLE_CYC (SETTLE_CYC)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .head_i       (head_i),
    .head_valid_i (head_valid_i),
    .pop_o        (pop_o),
    .now_o        (now_o),
    .exp_valid_o  (exp_valid_o),
    .exp_id_o     (exp_id_o),
    .exp_time_o   (exp_time_o),
    .exp_ready_i  (exp_ready_i),
    .late_cnt_o   (late_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Emulated priority queue contents (head is q[0]).
  cell_t q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int m_ticks;   // clock edges since reset release
  int m_cool;    // edges left before the head may be evaluated again
  bit m_pop;     // pop strobe expected this cycle
  bit m_valid;
  int m_id;
  int m_time;
  int m_late;

  // Observation helpers.
  int cyc;
  int pop_cnt;
  int pop_cyc[$];
  int pop_now[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int m_now();
    return (m_ticks / PRESCALE) % TMOD;
  endfunction

  task automatic model_reset();
    m_ticks = 0;
    m_cool  = 0;
    m_pop   = 0;
    m_valid = 0;
    m_id    = 0;
    m_time  = 0;
    m_late  = 0;
  endtask

  // Apply one clock edge to the model using the inputs held across it.
  task automatic model_edge();
    cell_t hd;
    bit    hv;
    bit    free;
    bit    new_pop;
    int    diff;
    hd      = head_i;
    hv      = head_valid_i;
    free    = !m_valid || exp_ready_i;
    diff    = (m_now() - int'(hd.data) + TMOD) % TMOD;
    new_pop = 0;
    if (m_pop) begin
      m_valid = 1;
      m_id    = int'(hd.id);
      m_time  = int'(hd.data);
      if (q.size() > 0) void'(q.pop_front());
    end else if (m_valid && exp_ready_i) begin
      m_valid = 0;
    end
    if (m_cool > 0) begin
      m_cool--;
    end else if (en_i && hv && diff < TMOD / 2 && free) begin
      new_pop = 1;
      m_cool  = SETTLE_CYC;
      if (diff != 0 && m_late < 65535) m_late++;
    end
    m_pop = new_pop;
    m_ticks++;
  endtask

  task automatic drive_head();
    if (q.size() > 0) begin
      head_valid_i = 1'b1;
      head_i       = q[0];
    end else begin
      head_valid_i = 1'b0;
      head_i       = cell_t'($urandom);   // must be ignored while empty
    end
  endtask

  task automatic compare();
    int exp_late;
`ifdef PQ_LATE_CNT_EN
    exp_late = m_late;
`else
    exp_late = 0;
`endif
    check("pop_o", 32'(pop_o), 32'(m_pop));
    check("exp_valid_o", 32'(exp_valid_o), 32'(m_valid));
    check("now_o", 32'(now_o), 32'(m_now()));
    check("late_cnt_o", 32'(late_cnt_o), 32'(exp_late));
    if (m_valid) begin
      check("exp_id_o", 32'(exp_id_o), 32'(m_id));
      check("exp_time_o", 32'(exp_time_o), 32'(m_time));
    end
  endtask

  // One clock: model steps on the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    cyc++;
    compare();
    if (pop_o) begin
      pop_cnt++;
      pop_cyc.push_back(cyc);
      pop_now.push_back(int'(now_o));
    end
    drive_head();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push(input int ts, input int id);
    cell_t c;
    c.data = TIME_WIDTH'(ts);
    c.id   = ID_WIDTH'(id);
    q.push_back(c);
    drive_head();
  endtask

  task automatic clear_obs();
    pop_cnt = 0;
    pop_cyc.delete();
    pop_now.delete();
  endtask

  initial begin
    int guard;
    int seen_id;

    cyc          = 0;
    rst_ni       = 1'b0;
    en_i         = 1'b0;
    exp_ready_i  = 1'b0;
    head_valid_i = 1'b0;
    head_i       = '0;
    model_reset();
    clear_obs();

    // Reset state.
    repeat (3) @(negedge clk_i);
    check("rst_pop", 32'(pop_o), 0);
    check("rst_valid", 32'(exp_valid_o), 0);
    check("rst_now", 32'(now_o), 0);
    check("rst_late", 32'(late_cnt_o), 0);
    check("rst_id", 32'(exp_id_o), 0);
    check("rst_time", 32'(exp_time_o), 0);
    rst_ni = 1'b1;

    // 1: single head {5,3} pops while now is 5.
    en_i = 1'b1;
    exp_ready_i = 1'b1;
    push(5, 3);
    guard = 0;
    while (!exp_valid_o && guard < 40) begin
      cycle();
      guard++;
    end
    check("s1_timeout", 32'(guard < 40), 1);
    check("s1_id", 32'(exp_id_o), 3);
    check("s1_time", 32'(exp_time_o), 5);
    check("s1_pops", 32'(pop_cnt), 1);
    if (pop_now.size() > 0) check("s1_pop_now", 32'(pop_now[0]), 5);
    else check("s1_pop_now", 32'hFFFF_FFFF, 5);
    run(4);

    // 2: downstream stall holds the output and blocks further pops.
    clear_obs();
    exp_ready_i = 1'b0;
    push(m_now(), 1);
    push(m_now(), 2);
    run(20);
    check("s2_stall_pops", 32'(pop_cnt), 1);
    check("s2_held_valid", 32'(exp_valid_o), 1);
    check("s2_held_id", 32'(exp_id_o), 1);
    clear_obs();
    exp_ready_i = 1'b1;
    run(20);
    check("s2_resume_pops", 32'(pop_cnt), 1);
    check("s2_resume_id", 32'(exp_id_o), 2);

    // 4: four due heads pop exactly SETTLE_CYC+1 cycles apart.
    clear_obs();
    for (int i = 0; i < 4; i++) push(m_now(), 4 + i);
    run(30);
    check("s4_pops", 32'(pop_cnt), 4);
    for (int i = 1; i < pop_cyc.size(); i++)
      check("s4_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'(SETTLE_CYC + 1));

    // 5: disabled dispatch never pops; dropping en_i mid-pop still completes.
    clear_obs();
    en_i = 1'b0;
    push(m_now(), 7);
    run(12);
    check("s5_no_pop", 32'(pop_cnt), 0);
    en_i = 1'b1;
    guard = 0;
    while (!pop_o && guard < 10) begin
      cycle();
      guard++;
    end
    check("s5_pop_seen", 32'(pop_o), 1);
    en_i = 1'b0;
    seen_id = -1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (exp_valid_o && seen_id < 0) seen_id = int'(exp_id_o);
    end
    check("s5_drop_en_id", 32'(seen_id), 7);
    en_i = 1'b1;

    // 3: wrap-around; late head at 250 pops at once, head 2 waits for the wrap.
    clear_obs();
    guard = 0;
    while (m_now() != 250 && guard < 1000) begin
      cycle();
      guard++;
    end
    check("s3_reach_250", 32'(m_now()), 250);
    push(200, 11);
    push(2, 12);
    run(40);
    check("s3_pops", 32'(pop_cnt), 2);
    if (pop_now.size() == 2) begin
      check("s3_late_now", 32'(pop_now[0]), 250);
      check("s3_wrap_now", 32'(pop_now[1]), 2);
    end else begin
      check("s3_pop_list", 32'(pop_now.size()), 2);
    end

    // 6: reset asserted during POP clears everything at once.
    push(m_now(), 9);
    guard = 0;
    while (!pop_o && guard < 20) begin
      cycle();
      guard++;
    end
    check("s6_pop_seen", 32'(pop_o), 1);
    rst_ni = 1'b0;
    #1;
    check("s6_rst_pop", 32'(pop_o), 0);
    check("s6_rst_valid", 32'(exp_valid_o), 0);
    check("s6_rst_now", 32'(now_o), 0);
    model_reset();
    q.delete();
    drive_head();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    clear_obs();
    push(3, 10);
    run(20);
    check("s6_resume_pops", 32'(pop_cnt), 1);
    check("s6_resume_id", 32'(exp_id_o), 10);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en_i        = ($urandom_range(0, 9) != 0);
      exp_ready_i = ($urandom_range(0, 3) != 0);
      if (q.size() < 6 && $urandom_range(0, 2) == 0)
        push((m_now() + $urandom_range(0, 30) + TMOD - 10) % TMOD, $urandom_range(0, 15));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
